// File: rtl/drum_sample_streamer.sv
// drum_sample_streamer
//   Captures the drum mesh centre-node sample once per simulation step. The
//   sample is decimated, shifted by GAIN_SHIFT, saturated to 16-bit PCM and
//   queued in a FIFO whose head register drives a valid/ready audio bus.
// Ports
//   clock, reset         posedge clock, synchronous active-low reset
//   enable               capture strobes when 1; clears the decimation count when 0
//   sample_in[17:0]      signed 1.17 displacement, valid when sample_strobe is 1
//   sample_strobe        one-cycle pulse per simulation step
//   audio_data[15:0]     PCM word at the FIFO head
//   audio_valid          audio_data holds a sample
//   audio_ready          consumer takes the head when valid && ready
//   fifo_level           samples held, including the head register
//   overflow_cnt[7:0]    samples dropped because the FIFO was full (saturating)
module drum_sample_streamer #(
    parameter int DEPTH      = 16,
    parameter int DECIM      = 1,
    parameter int GAIN_SHIFT = 0
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       enable,
    input  logic [17:0]                sample_in,
    input  logic                       sample_strobe,
    output logic [15:0]                audio_data,
    output logic                       audio_valid,
    input  logic                       audio_ready,
    output logic [$clog2(DEPTH):0]     fifo_level,
    output logic [7:0]                 overflow_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic signed [24:0] SMAX = 25'sd131071;
    localparam logic signed [24:0] SMIN = -25'sd131072;

    logic [7:0]             decim_cnt_q, decim_cnt_d;
    logic                   s1_valid_q, s1_valid_d;
    logic [15:0]            s1_data_q, s1_data_d;
    logic [DEPTH-1:0][15:0] mem_q, mem_d;
    logic [AW-1:0]          rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [LW-1:0]          cnt_q, cnt_d;
    logic [15:0]            head_data_q, head_data_d;
    logic                   head_valid_q, head_valid_d;
    logic [7:0]             ovf_q, ovf_d;

    logic                   keep, pop, full, wr, drop, load;
    logic signed [24:0]     wide;
    logic [15:0]            pcm;
    logic [LW-1:0]          level;

    always_comb begin
        keep = sample_strobe && enable && (decim_cnt_q == 8'(DECIM - 1));
        decim_cnt_d = decim_cnt_q;
        if (!enable)
            decim_cnt_d = '0;
        else if (sample_strobe)
            decim_cnt_d = keep ? 8'd0 : decim_cnt_q + 8'd1;

        // Sign-extend to 25 bits so the largest gain cannot wrap before saturation.
        wide = $signed({{7{sample_in[17]}}, sample_in}) <<< GAIN_SHIFT;
        if (wide > SMAX)      pcm = 16'h7FFF;
        else if (wide < SMIN) pcm = 16'h8000;
        else                  pcm = wide[17:2];
        s1_valid_d = keep;
        s1_data_d  = keep ? pcm : s1_data_q;

        pop   = head_valid_q && audio_ready;
        level = cnt_q + LW'(head_valid_q);
        // Fullness is judged before this edge's pop; a same-edge pop frees a slot.
        full  = (level == LW'(DEPTH + 1));
        wr    = s1_valid_q && (!full || pop);
        drop  = s1_valid_q && full && !pop;
        // Head refills whenever it is empty or being consumed, giving back-to-back beats.
        load  = (cnt_q != '0) && (!head_valid_q || pop);

        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        if (wr) begin
            mem_d[wr_ptr_q] = s1_data_q;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end

        head_data_d  = head_data_q;
        head_valid_d = head_valid_q;
        rd_ptr_d     = rd_ptr_q;
        if (load) begin
            head_data_d  = mem_q[rd_ptr_q];
            head_valid_d = 1'b1;
            rd_ptr_d     = rd_ptr_q + AW'(1);
        end else if (pop) begin
            head_valid_d = 1'b0;
        end

        cnt_d = cnt_q + LW'(wr) - LW'(load);
        ovf_d = (drop && ovf_q != 8'hFF) ? ovf_q + 8'd1 : ovf_q;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            decim_cnt_q  <= '0;
            s1_valid_q   <= 1'b0;
            s1_data_q    <= '0;
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            cnt_q        <= '0;
            head_data_q  <= '0;
            head_valid_q <= 1'b0;
            ovf_q        <= '0;
        end else begin
            decim_cnt_q  <= decim_cnt_d;
            s1_valid_q   <= s1_valid_d;
            s1_data_q    <= s1_data_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            cnt_q        <= cnt_d;
            head_data_q  <= head_data_d;
            head_valid_q <= head_valid_d;
            ovf_q        <= ovf_d;
        end
    end

    // Storage needs no reset: the pointers and count decide what is live.
    always_ff @(posedge clock) mem_q <= mem_d;

    assign audio_data   = head_data_q;
    assign audio_valid  = head_valid_q;
    assign fifo_level   = level;
    assign overflow_cnt = ovf_q;
endmodule

// File: tb/tb_drum_sample_streamer.sv
module tb_drum_sample_streamer;
    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        enable = 1'b1;
    logic [17:0] sample_in = '0;
    logic        sample_strobe = 1'b0;

    // a: defaults, g: GAIN_SHIFT=2, d: DECIM=4, f: DEPTH=4
    logic [15:0] data_a, data_g, data_d, data_f;
    logic        valid_a, valid_g, valid_d, valid_f;
    logic        ready_a = 1'b0, ready_g = 1'b0, ready_d = 1'b0, ready_f = 1'b0;
    logic [4:0]  level_a, level_g, level_d;
    logic [2:0]  level_f;
    logic [7:0]  ovf_a, ovf_g, ovf_d, ovf_f;

    int n_asserts = 0;
    int n_fail    = 0;
    logic [15:0] got[$];

    always #5 clock = ~clock;

    drum_sample_streamer dut_a (.clock(clock), .reset(reset), .enable(enable),
        .sample_in(sample_in), .sample_strobe(sample_strobe), .audio_data(data_a),
        .audio_valid(valid_a), .audio_ready(ready_a), .fifo_level(level_a), .overflow_cnt(ovf_a));
    drum_sample_streamer #(.GAIN_SHIFT(2)) dut_g (.clock(clock), .reset(reset), .enable(enable),
        .sample_in(sample_in), .sample_strobe(sample_strobe), .audio_data(data_g),
        .audio_valid(valid_g), .audio_ready(ready_g), .fifo_level(level_g), .overflow_cnt(ovf_g));
    drum_sample_streamer #(.DECIM(4)) dut_d (.clock(clock), .reset(reset), .enable(enable),
        .sample_in(sample_in), .sample_strobe(sample_strobe), .audio_data(data_d),
        .audio_valid(valid_d), .audio_ready(ready_d), .fifo_level(level_d), .overflow_cnt(ovf_d));
    drum_sample_streamer #(.DEPTH(4)) dut_f (.clock(clock), .reset(reset), .enable(enable),
        .sample_in(sample_in), .sample_strobe(sample_strobe), .audio_data(data_f),
        .audio_valid(valid_f), .audio_ready(ready_f), .fifo_level(level_f), .overflow_cnt(ovf_f));

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        sample_strobe = 1'b0;
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    initial begin
        // 1: reset, strobe held during reset must not write
        sample_in = 18'h10000;
        sample_strobe = 1'b1;
        tick();
        tick();
        chk("rst_data", 32'(data_a), 32'h0);
        chk("rst_valid", 32'(valid_a), 32'h0);
        chk("rst_level", 32'(level_a), 32'h0);
        chk("rst_ovf", 32'(ovf_a), 32'h0);
        sample_strobe = 1'b0;
        reset = 1'b1;
        tick(); tick(); tick();
        chk("rst_nowrite_valid", 32'(valid_a), 32'h0);
        chk("rst_nowrite_level", 32'(level_a), 32'h0);

        // 2: 0.5 at unity gain, two-clock latency, one-cycle beat
        ready_a = 1'b1;
        sample_in = 18'h10000;
        sample_strobe = 1'b1;
        tick();
        sample_strobe = 1'b0;
        tick();
        chk("lat_e1_valid", 32'(valid_a), 32'h0);
        tick();
        chk("lat_e2_valid", 32'(valid_a), 32'h1);
        chk("lat_e2_data", 32'(data_a), 32'h4000);
        chk("lat_e2_level", 32'(level_a), 32'h1);
        tick();
        chk("lat_e3_valid", 32'(valid_a), 32'h0);
        chk("lat_e3_level", 32'(level_a), 32'h0);

        // 3: gain 2 saturation, back-to-back strobes
        do_reset();
        ready_g = 1'b1;
        sample_strobe = 1'b1;
        sample_in = 18'h10000; tick();
        sample_in = 18'h30000; tick();
        sample_in = 18'h3FFFF; tick();
        sample_strobe = 1'b0;
        chk("gain_pos_sat", 32'(data_g), 32'h7FFF);
        chk("gain_pos_valid", 32'(valid_g), 32'h1);
        tick();
        chk("gain_neg_sat", 32'(data_g), 32'h8000);
        tick();
        chk("gain_m1lsb", 32'(data_g), 32'hFFFF);
        tick();
        chk("gain_drained", 32'(valid_g), 32'h0);

        // 4: decimate by 4, values 1..12
        do_reset();
        ready_d = 1'b1;
        got.delete();
        for (int k = 1; k <= 12; k++) begin
            sample_in = 18'(k << 2);
            sample_strobe = 1'b1;
            tick();
            if (valid_d) got.push_back(data_d);
        end
        sample_strobe = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (valid_d) got.push_back(data_d);
        end
        chk("decim_count", 32'(got.size()), 32'd3);
        if (got.size() == 3) begin
            chk("decim_s0", 32'(got[0]), 32'd4);
            chk("decim_s1", 32'(got[1]), 32'd8);
            chk("decim_s2", 32'(got[2]), 32'd12);
        end

        // 5: DEPTH=4 overflow, then ordered drain
        do_reset();
        ready_f = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            sample_in = 18'(k << 2);
            sample_strobe = 1'b1;
            tick();
        end
        sample_strobe = 1'b0;
        tick(); tick();
        chk("full_level", 32'(level_f), 32'd5);
        chk("full_ovf", 32'(ovf_f), 32'd3);
        chk("full_head", 32'(data_f), 32'd1);
        tick();
        chk("stall_hold_data", 32'(data_f), 32'd1);
        chk("stall_hold_valid", 32'(valid_f), 32'h1);
        ready_f = 1'b1;
        for (int k = 2; k <= 5; k++) begin
            tick();
            chk("drain_data", 32'(data_f), 32'(k));
            chk("drain_valid", 32'(valid_f), 32'h1);
        end
        tick();
        chk("drain_empty_valid", 32'(valid_f), 32'h0);
        chk("drain_empty_level", 32'(level_f), 32'd0);
        chk("drain_ovf_kept", 32'(ovf_f), 32'd3);

        // 6: full FIFO, write coincides with pop
        do_reset();
        ready_f = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            sample_in = 18'(k << 2);
            sample_strobe = 1'b1;
            tick();
        end
        sample_strobe = 1'b0;
        tick(); tick();
        chk("cpop_pre_level", 32'(level_f), 32'd5);
        sample_in = 18'(9 << 2);
        sample_strobe = 1'b1;
        tick();
        sample_strobe = 1'b0;
        ready_f = 1'b1;
        tick();
        ready_f = 1'b0;
        chk("cpop_level", 32'(level_f), 32'd5);
        chk("cpop_ovf", 32'(ovf_f), 32'd0);
        chk("cpop_head", 32'(data_f), 32'd2);
        ready_f = 1'b1;
        got.delete();
        for (int k = 0; k < 6; k++) begin
            if (valid_f) got.push_back(data_f);
            tick();
        end
        chk("cpop_drain_count", 32'(got.size()), 32'd5);
        if (got.size() == 5) chk("cpop_last", 32'(got[4]), 32'd9);

        // reset in the middle of a burst
        for (int k = 1; k <= 4; k++) begin
            sample_in = 18'(k << 2);
            sample_strobe = 1'b1;
            tick();
        end
        reset = 1'b0;
        tick();
        chk("midrst_valid", 32'(valid_f), 32'h0);
        chk("midrst_level", 32'(level_f), 32'd0);
        sample_strobe = 1'b0;
        reset = 1'b1;
        tick(); tick(); tick();
        chk("midrst_no_partial", 32'(valid_f), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end
endmodule
